window_line_buffer: RTL and testbench

- Streaming 3x3 neighbourhood generator for raster-order grayscale pixels. It replaces the address-driven nine-port read RAM with two circular line buffers and a 3x3 register window.
- Sits between the grayscale converter and the convolution/edge-detection stage. It emits one complete window per accepted input pixel once two full lines and two columns of history exist.
- Generalised in pixel width, line length and frame height. Adds start-of-frame resync and a frame-done pulse.

---
 rtl/winbuf_pkg.sv | 26 ++
 rtl/line_ram.sv | 30 +++
 rtl/window_line_buffer.sv | 220 ++++++++++++++++++++++
 tb/tb_window_line_buffer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/winbuf_pkg.sv
// Shared constants and types for the 3x3 window line buffer.
// Tap k = r*3 + c. Row 0 is the top row and column 0 is the left column.
package winbuf_pkg;

    localparam int WIN_TAPS = 9;

    localparam int TAP_LU = 0;
    localparam int TAP_U  = 1;
    localparam int TAP_RU = 2;
    localparam int TAP_L  = 3;
    localparam int TAP_C  = 4;
    localparam int TAP_R  = 5;
    localparam int TAP_LD = 6;
    localparam int TAP_D  = 7;
    localparam int TAP_RD = 8;

    // Line RAM read latency, and accept-to-out_valid latency.
    localparam int LB_LATENCY  = 1;
    localparam int WIN_LATENCY = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line RAM with one write port and one registered read port.
// If a read and a write hit the same address in the same cycle, the read
// returns the old contents. rdata holds its value while re is low.
module line_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    (* ram_style = "block" *) logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Write port, plus a registered read that sees the old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/window_line_buffer.sv
// Streaming 3x3 window generator for raster-order pixels.
// Two line RAMs hold rows y-1 and y-2. A column register window produces one
// interior window per accepted pixel at (x>=2, y>=2). The window is centred on
// (x-1, y-1) and appears two clocks after the pixel is accepted.
// Optional build macro WINBUF_COORD_EN adds the out_x and out_y centre outputs.
module window_line_buffer
    import winbuf_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int LINE_W  = 640,
    parameter int FRAME_H = 480,
    parameter int X_W     = $clog2(LINE_W),
    parameter int Y_W     = $clog2(FRAME_H)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    output logic [WIN_TAPS*DATA_W-1:0] out_win,
    output logic                       frame_done
`ifdef WINBUF_COORD_EN
    ,
    output logic [X_W-1:0]             out_x,
    output logic [Y_W-1:0]             out_y
`endif
);

    localparam logic [X_W-1:0] X_LAST = X_W'(LINE_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(FRAME_H - 1);

    // Stage timing below assumes one cycle of RAM read and one window stage.
    if (LB_LATENCY != 1 || WIN_LATENCY != LB_LATENCY + 1) begin : g_latency_check
        $error("window_line_buffer: pipeline depth does not match LB_LATENCY/WIN_LATENCY");
    end

    state_t         state_q, state_d;
    logic [X_W-1:0] x_q, x_nxt, cur_x;
    logic [Y_W-1:0] y_q, y_nxt, cur_y;
    logic           accept;
    logic           last_col, last_row;
    logic           frame_end;
    logic           gate;

    // Stage 1: the accepted pixel, delayed to line up with the RAM read data.
    logic              s1_valid;
    logic              s1_gate;
    logic [X_W-1:0]    s1_x;
    logic [DATA_W-1:0] s1_data;
`ifdef WINBUF_COORD_EN
    logic [Y_W-1:0]    s1_y;
`endif

    logic [DATA_W-1:0] lb0_rd, lb1_rd;

    // Left and middle window columns. Row r is at bits [r*DATA_W +: DATA_W].
    logic [3*DATA_W-1:0]        col_l_q, col_m_q, col_new;
    logic [WIN_TAPS*DATA_W-1:0] win_next;

    // Next state, accept qualification and the position of the accepted pixel.
    // An sof pixel is always treated as (0,0), which also restarts a frame that
    // is already running.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        cur_x   = x_q;
        cur_y   = y_q;
        if (in_valid && in_sof) begin
            accept  = 1'b1;
            cur_x   = '0;
            cur_y   = '0;
            state_d = RUN;
        end else if (in_valid && state_q == RUN) begin
            accept = 1'b1;
        end
    end

    // Raster counter advance, frame-end detect and the interior-window gate.
    always_comb begin
        last_col  = (cur_x == X_LAST);
        last_row  = (cur_y == Y_LAST);
        x_nxt     = x_q;
        y_nxt     = y_q;
        if (accept) begin
            if (last_col) begin
                x_nxt = '0;
                y_nxt = last_row ? '0 : cur_y + 1'b1;
            end else begin
                x_nxt = cur_x + 1'b1;
                y_nxt = cur_y;
            end
        end
        frame_end = accept && last_col && last_row;
        gate      = (cur_x >= X_W'(2)) && (cur_y >= Y_W'(2));
    end

    // State register, raster counters and frame_done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_nxt;
            y_q        <= y_nxt;
            frame_done <= frame_end;
        end
    end

    // lb0 holds row y-1. It is read and rewritten at the same column on every accept.
    line_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (LINE_W),
        .ADDR_W (X_W)
    ) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .waddr (cur_x),
        .wdata (in_data),
        .re    (accept),
        .raddr (cur_x),
        .rdata (lb0_rd)
    );

    // lb1 holds row y-2. The old lb0 word only arrives one cycle after the
    // accept, so its write into lb1 is done one cycle late at the same column.
    // That column is not read again until the next line.
    line_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (LINE_W),
        .ADDR_W (X_W)
    ) u_lb1 (
        .clk   (clk),
        .we    (s1_valid),
        .waddr (s1_x),
        .wdata (lb0_rd),
        .re    (accept),
        .raddr (cur_x),
        .rdata (lb1_rd)
    );

    // Stage-1 register that tracks the pixel whose RAM reads are in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_gate  <= 1'b0;
            s1_x     <= '0;
            s1_data  <= '0;
`ifdef WINBUF_COORD_EN
            s1_y     <= '0;
`endif
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_gate <= gate;
                s1_x    <= cur_x;
                s1_data <= in_data;
`ifdef WINBUF_COORD_EN
                s1_y    <= cur_y;
`endif
            end
        end
    end

    // Assemble the incoming column and the full window it completes.
    always_comb begin
        col_new  = {s1_data, lb0_rd, lb1_rd};
        win_next = '0;
        win_next[TAP_LU*DATA_W +: DATA_W] = col_l_q[0*DATA_W +: DATA_W];
        win_next[TAP_U *DATA_W +: DATA_W] = col_m_q[0*DATA_W +: DATA_W];
        win_next[TAP_RU*DATA_W +: DATA_W] = col_new[0*DATA_W +: DATA_W];
        win_next[TAP_L *DATA_W +: DATA_W] = col_l_q[1*DATA_W +: DATA_W];
        win_next[TAP_C *DATA_W +: DATA_W] = col_m_q[1*DATA_W +: DATA_W];
        win_next[TAP_R *DATA_W +: DATA_W] = col_new[1*DATA_W +: DATA_W];
        win_next[TAP_LD*DATA_W +: DATA_W] = col_l_q[2*DATA_W +: DATA_W];
        win_next[TAP_D *DATA_W +: DATA_W] = col_m_q[2*DATA_W +: DATA_W];
        win_next[TAP_RD*DATA_W +: DATA_W] = col_new[2*DATA_W +: DATA_W];
    end

    // Shift the column window only on accepted pixels, so input gaps leave it intact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_l_q <= '0;
            col_m_q <= '0;
        end else if (s1_valid) begin
            col_l_q <= col_m_q;
            col_m_q <= col_new;
        end
    end

    // Output register. It loads only for interior windows and holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_win   <= '0;
        end else begin
            out_valid <= s1_valid && s1_gate;
            if (s1_valid && s1_gate) begin
                out_win <= win_next;
            end
        end
    end

`ifdef WINBUF_COORD_EN
    // Window-centre coordinates, aligned with out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_x <= '0;
            out_y <= '0;
        end else if (s1_valid && s1_gate) begin
            out_x <= s1_x - 1'b1;
            out_y <= s1_y - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_window_line_buffer.sv
// Directed self-checking bench for window_line_buffer (LINE_W=8, FRAME_H=6).
// Pixel value = base + y*16 + x. Each scenario task drives pixels, records the
// windows and frame_done pulses it expects with their exact cycle numbers, and
// compares them against what the monitor captured.
module tb_window_line_buffer;

    localparam int DW    = 8;
    localparam int LW    = 8;
    localparam int FH    = 6;
    localparam int WIN_W = 9 * DW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic [DW-1:0]    in_data = '0;
    logic             out_valid;
    logic [WIN_W-1:0] out_win;
    logic             frame_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [WIN_W-1:0] exp_win[$];
    int               exp_cyc[$];
    int               exp_fd[$];
    logic [WIN_W-1:0] obs_win[$];
    int               obs_cyc[$];
    int               obs_fd[$];

    window_line_buffer #(
        .DATA_W  (DW),
        .LINE_W  (LW),
        .FRAME_H (FH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_win    (out_win),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            obs_win.push_back(out_win);
            obs_cyc.push_back(cyc);
        end
        if (frame_done) obs_fd.push_back(cyc);
    end

    function automatic logic [DW-1:0] pix(input logic [DW-1:0] base, input int x, input int y);
        return base + DW'(y * 16 + x);
    endfunction

    // Expected window for the pixel accepted at (x,y), centred on (x-1,y-1).
    function automatic logic [WIN_W-1:0] win_of(input logic [DW-1:0] base, input int x, input int y);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*DW +: DW] = pix(base, x - 2 + c, y - 2 + r);
        return w;
    endfunction

    task automatic send(input int x, input int y, input logic sof, input logic [DW-1:0] base,
                        input logic expect_out);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = pix(base, x, y);
        if (expect_out && x >= 2 && y >= 2) begin
            exp_win.push_back(win_of(base, x, y));
            exp_cyc.push_back(cyc + 2);
        end
        if (expect_out && x == LW - 1 && y == FH - 1) exp_fd.push_back(cyc + 1);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input logic first_sof, input int max_gap,
                              input logic expect_out);
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < LW; x++) begin
                send(x, y, first_sof && x == 0 && y == 0, base, expect_out);
                if (max_gap > 0) gap($urandom_range(0, max_gap));
            end
    endtask

    task automatic drain();
        gap(4);
        exp_win.delete(); exp_cyc.delete(); exp_fd.delete();
        obs_win.delete(); obs_cyc.delete(); obs_fd.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        checks++; if (out_win !== '0) begin errors++; $display("FAIL reset out_win: got %h want 0", out_win); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_full_frame();
        logic [WIN_W-1:0] first;
        logic [DW-1:0]    centre;
        drain();
        send_frame(8'h00, 1'b1, 0, 1'b1);
        gap(4);
        checks++; if (obs_win.size() !== 24) begin errors++; $display("FAIL full_frame count: got %0d want 24", obs_win.size()); end
        if (obs_win.size() > 0) begin
            first  = obs_win[0];
            centre = first[4*DW +: DW];
            checks++; if (first !== 72'h22_21_20_12_11_10_02_01_00) begin errors++; $display("FAIL full_frame first_win: got %h want 222120121110020100", first); end
            checks++; if (centre !== 8'h11) begin errors++; $display("FAIL full_frame centre: got %h want 11", centre); end
        end
        for (int i = 0; i < exp_win.size() && i < obs_win.size(); i++) begin
            checks++;
            if (obs_win[i] !== exp_win[i] || obs_cyc[i] !== exp_cyc[i]) begin
                errors++; $display("FAIL full_frame win[%0d]: got %h@%0d want %h@%0d", i, obs_win[i], obs_cyc[i], exp_win[i], exp_cyc[i]);
            end
        end
        checks++; if (obs_fd.size() !== 1 || obs_fd[0] !== exp_fd[0]) begin errors++; $display("FAIL full_frame frame_done: got %0d pulses want 1 at %0d", obs_fd.size(), exp_fd[0]); end
    endtask

    task automatic test_gaps();
        drain();
        send_frame(8'h00, 1'b1, 3, 1'b1);
        gap(4);
        checks++; if (obs_win.size() !== 24) begin errors++; $display("FAIL gaps count: got %0d want 24", obs_win.size()); end
        for (int i = 0; i < exp_win.size() && i < obs_win.size(); i++) begin
            checks++;
            if (obs_win[i] !== exp_win[i] || obs_cyc[i] !== exp_cyc[i]) begin
                errors++; $display("FAIL gaps win[%0d]: got %h@%0d want %h@%0d", i, obs_win[i], obs_cyc[i], exp_win[i], exp_cyc[i]);
            end
        end
        checks++; if (obs_fd.size() !== 1 || obs_fd[0] !== exp_fd[0]) begin errors++; $display("FAIL gaps frame_done: got %0d pulses want 1 at %0d", obs_fd.size(), exp_fd[0]); end
    endtask

    task automatic test_no_sof();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drain();
        send_frame(8'h00, 1'b0, 0, 1'b0);
        gap(4);
        checks++; if (obs_win.size() !== 0) begin errors++; $display("FAIL no_sof out_valid: got %0d windows want 0", obs_win.size()); end
        checks++; if (obs_fd.size() !== 0) begin errors++; $display("FAIL no_sof frame_done: got %0d pulses want 0", obs_fd.size()); end
        send_frame(8'h20, 1'b1, 0, 1'b1);
        gap(4);
        checks++; if (obs_win.size() !== 24) begin errors++; $display("FAIL no_sof after_sof count: got %0d want 24", obs_win.size()); end
        for (int i = 0; i < exp_win.size() && i < obs_win.size(); i++) begin
            checks++;
            if (obs_win[i] !== exp_win[i] || obs_cyc[i] !== exp_cyc[i]) begin
                errors++; $display("FAIL no_sof win[%0d]: got %h@%0d want %h@%0d", i, obs_win[i], obs_cyc[i], exp_win[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_abort();
        drain();
        for (int y = 0; y <= 3; y++)
            for (int x = 0; x < LW; x++)
                if (!(y == 3 && x >= 5)) send(x, y, x == 0 && y == 0, 8'h00, 1'b1);
        send_frame(8'h80, 1'b1, 0, 1'b1);
        gap(4);
        checks++; if (obs_win.size() !== 33) begin errors++; $display("FAIL abort count: got %0d want 33", obs_win.size()); end
        for (int i = 0; i < exp_win.size() && i < obs_win.size(); i++) begin
            checks++;
            if (obs_win[i] !== exp_win[i] || obs_cyc[i] !== exp_cyc[i]) begin
                errors++; $display("FAIL abort win[%0d]: got %h@%0d want %h@%0d", i, obs_win[i], obs_cyc[i], exp_win[i], exp_cyc[i]);
            end
        end
        checks++; if (obs_fd.size() !== 1 || obs_fd[0] !== exp_fd[0]) begin errors++; $display("FAIL abort frame_done: got %0d pulses want 1 at %0d", obs_fd.size(), exp_fd[0]); end
    endtask

    task automatic test_back_to_back();
        drain();
        send_frame(8'h00, 1'b1, 0, 1'b1);
        send_frame(8'h40, 1'b0, 0, 1'b1);
        gap(4);
        checks++; if (obs_win.size() !== 48) begin errors++; $display("FAIL back_to_back count: got %0d want 48", obs_win.size()); end
        for (int i = 0; i < exp_win.size() && i < obs_win.size(); i++) begin
            checks++;
            if (obs_win[i] !== exp_win[i] || obs_cyc[i] !== exp_cyc[i]) begin
                errors++; $display("FAIL back_to_back win[%0d]: got %h@%0d want %h@%0d", i, obs_win[i], obs_cyc[i], exp_win[i], exp_cyc[i]);
            end
        end
        checks++; if (obs_fd.size() !== 2) begin errors++; $display("FAIL back_to_back fd_count: got %0d want 2", obs_fd.size()); end
        for (int i = 0; i < exp_fd.size() && i < obs_fd.size(); i++) begin
            checks++;
            if (obs_fd[i] !== exp_fd[i]) begin errors++; $display("FAIL back_to_back fd[%0d]: got %0d want %0d", i, obs_fd[i], exp_fd[i]); end
        end
    endtask

    task automatic test_reset_mid();
        drain();
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x < LW; x++)
                if (!(y == 4 && x >= 4)) send(x, y, x == 0 && y == 0, 8'h00, !(y == 4 && x == 3));
        @(posedge clk); #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_data  = pix(8'h00, 4, 4);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid out_valid: got %b want 0", out_valid); end
        checks++; if (out_win !== '0) begin errors++; $display("FAIL reset_mid out_win: got %h want 0", out_win); end
        // Pixels without sof must be ignored because the reset returns the block to IDLE.
        for (int i = 0; i < 20; i++) send(i % LW, 2 + i / LW, 1'b0, 8'h00, 1'b0);
        gap(4);
        send_frame(8'h60, 1'b1, 0, 1'b1);
        gap(4);
        checks++; if (obs_win.size() !== 37) begin errors++; $display("FAIL reset_mid count: got %0d want 37", obs_win.size()); end
        for (int i = 0; i < exp_win.size() && i < obs_win.size(); i++) begin
            checks++;
            if (obs_win[i] !== exp_win[i] || obs_cyc[i] !== exp_cyc[i]) begin
                errors++; $display("FAIL reset_mid win[%0d]: got %h@%0d want %h@%0d", i, obs_win[i], obs_cyc[i], exp_win[i], exp_cyc[i]);
            end
        end
        checks++; if (obs_fd.size() !== 1 || obs_fd[0] !== exp_fd[0]) begin errors++; $display("FAIL reset_mid frame_done: got %0d pulses want 1 at %0d", obs_fd.size(), exp_fd[0]); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_no_sof();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
